// File: rtl/i2c_master.sv
// I2C single-master controller: START, 7-bit address + R/W, N data bytes
// (write or read), ACK/NACK handling, STOP. Open-drain pad enables.
// Handshakes: wr_ready is high for exactly one clock, and wr_data is captured
// on the rising edge that ends that clock. rd_valid is high for exactly one
// clock, and rd_data is valid during that clock and held until the next byte.
// Neither handshake can be stalled.
module i2c_master #(
  parameter int DIV      = 250,
  parameter int NBYTES_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [6:0]          addr,
  input  logic                rw,
  input  logic [NBYTES_W-1:0] nbytes,
  input  logic [7:0]          wr_data,
  output logic                wr_ready,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                ack_err,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                sda_in,
  output logic [3:0]          state_dbg
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
  } state_t;

  state_t                state, state_next;
  logic [DW-1:0]         div_q;
  logic [1:0]            qtr;
  logic [1:0]            last_q;
  logic [2:0]            bitcnt;
  logic [7:0]            sh;
  logic [NBYTES_W-1:0]   cnt;
  logic                  rw_q;
  logic                  ack_bit;
  logic                  tick;
  logic                  cell_end;
  logic                  accept;
  logic                  load_wr;

  // A start arriving while busy, or on the cycle done pulses, is dropped.
  assign accept    = start && (state == IDLE) && !done;
  assign tick      = (state != IDLE) && (div_q == DW'(DIV - 1));
  assign cell_end  = tick && (qtr == 2'd3);
  assign busy      = (state != IDLE);
  assign wr_ready  = load_wr;
  assign state_dbg = state;

  // Last quarter index of the current step: START has 2, STOP 3, cells 4.
  always_comb begin
    last_q = 2'd3;
    if (state == START)     last_q = 2'd1;
    else if (state == STOP) last_q = 2'd2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and pad-enable decode; SCL is pulled low in q0/q1 of every cell.
  always_comb begin
    state_next = state;
    load_wr    = 1'b0;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        sda_oe = 1'b1;
        scl_oe = (qtr == 2'd1);
        if (tick && qtr == 2'd1) state_next = ADDR;
      end
      ADDR: begin
        scl_oe = ~qtr[1];
        sda_oe = ~sh[7];
        if (cell_end && bitcnt == 3'd7) state_next = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_oe = ~qtr[1];
        if (cell_end) begin
          if (ack_bit || cnt == '0) state_next = STOP;
          else if (!rw_q) begin
            state_next = WRITE;
            load_wr    = 1'b1;
          end else state_next = READ;
        end
      end
      WRITE: begin
        scl_oe = ~qtr[1];
        sda_oe = ~sh[7];
        if (cell_end && bitcnt == 3'd7) state_next = WRITE_ACK;
      end
      WRITE_ACK: begin
        scl_oe = ~qtr[1];
        if (cell_end) begin
          if (!ack_bit && cnt != NBYTES_W'(1)) begin
            state_next = WRITE;
            load_wr    = 1'b1;
          end else state_next = STOP;
        end
      end
      READ: begin
        scl_oe = ~qtr[1];
        if (cell_end && bitcnt == 3'd7) state_next = READ_ACK;
      end
      READ_ACK: begin
        scl_oe = ~qtr[1];
        sda_oe = (cnt != NBYTES_W'(1));
        if (cell_end) state_next = (cnt != NBYTES_W'(1)) ? READ : STOP;
      end
      STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr != 2'd2);
        if (tick && qtr == 2'd2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Quarter divider, bit/byte counters, shift register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      qtr      <= 2'd0;
      bitcnt   <= 3'd0;
      sh       <= 8'h00;
      cnt      <= '0;
      rw_q     <= 1'b0;
      ack_bit  <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE || tick) div_q <= '0;
      else                       div_q <= div_q + DW'(1);
      if (accept) begin
        sh      <= {addr, rw};
        rw_q    <= rw;
        cnt     <= nbytes;
        ack_err <= 1'b0;
        qtr     <= 2'd0;
        bitcnt  <= 3'd0;
      end
      if (tick) begin
        qtr <= (qtr == last_q) ? 2'd0 : qtr + 2'd1;
        // Slave data and ACK bits are sampled at the end of q2 (SCL high).
        if (qtr == 2'd2) begin
          ack_bit <= sda_in;
          if (state == READ) sh <= {sh[6:0], sda_in};
        end
        if (qtr == 2'd3) begin
          if (state == ADDR || state == WRITE || state == READ)
            bitcnt <= bitcnt + 3'd1;
          if (state == ADDR || state == WRITE) sh <= {sh[6:0], 1'b0};
          if (state == READ && bitcnt == 3'd7) begin
            rd_data  <= sh;
            rd_valid <= 1'b1;
          end
          if ((state == ADDR_ACK || state == WRITE_ACK) && ack_bit) ack_err <= 1'b1;
          if (state == WRITE_ACK || state == READ_ACK) cnt <= cnt - NBYTES_W'(1);
        end
        if (state == STOP && qtr == 2'd2) done <= 1'b1;
      end
      // Loading the next write byte overrides the address/data shift.
      if (load_wr) sh <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: vector table of whole transactions against a
// reactive slave model, plus hand-written reset, busy-guard and done-cycle cases.
module tb_i2c_master;
  localparam int DIV = 4;
  localparam int NW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    addr = 7'h00;
  logic          rw = 1'b0;
  logic [NW-1:0] nbytes = '0;
  logic [7:0]    wr_data;
  logic          wr_ready, rd_valid, busy, done, ack_err, scl_oe, sda_oe;
  logic [7:0]    rd_data;
  logic [3:0]    state_dbg;
  logic          sda_in;
  logic          slave_low = 1'b0;

  // Open-drain bus: the line is low if either side pulls it.
  assign sda_in = ~(sda_oe | slave_low);

  i2c_master #(.DIV(DIV), .NBYTES_W(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .nbytes(nbytes),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [3:0] n;
    logic [7:0] wd0, wd1, rd0, rd1;
    logic       ack_addr, ack_data, exp_err;
    int         exp_cyc, exp_wr, exp_rd;
  } vec_t;

  vec_t vecs[6];

  // Slave configuration (written by the test sequence only).
  logic       s_ack_addr = 1'b1, s_ack_data = 1'b1, s_rw = 1'b0;
  int         s_n = 0;
  logic [7:0] s_rd[0:1];
  logic [7:0] wbytes[0:3];

  // Monitor state (written by the monitor only).
  int         cyc = 0, fall_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int         busy_t = 0, done_t = 0;
  logic       scl_prev = 1'b0, busy_prev = 1'b0;
  logic       mlog[0:63];
  logic [7:0] rd_q[$];
  logic [7:0] exp_q[$];

  int n_checks = 0, n_fail = 0;

  function automatic logic slave_low_for(input int c);
    int j, b;
    if (c == 8) return s_ack_addr;
    if (c < 9) return 1'b0;
    j = (c - 9) / 9;
    b = (c - 9) % 9;
    if (j >= s_n || j > 1) return 1'b0;
    if (s_rw) return (b == 8) ? 1'b0 : ~s_rd[j][7-b];
    return (b == 8) ? s_ack_data : 1'b0;
  endfunction

  function automatic logic [7:0] log_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mlog[base+i];
    return b;
  endfunction

  // Slave model and event monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    wr_data = (wr_cnt < 4) ? wbytes[wr_cnt] : 8'h00;
    if (start && !busy && !done) begin
      fall_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
      rd_q.delete();
      wr_data = wbytes[0];
    end
    if (busy && !busy_prev) busy_t = cyc;
    if (busy) begin
      if (scl_oe && !scl_prev) begin
        slave_low = slave_low_for(fall_cnt);
        fall_cnt++;
      end else if (!scl_oe && scl_prev && fall_cnt > 0 && fall_cnt <= 64) begin
        mlog[fall_cnt-1] = ~sda_oe;
      end
    end else slave_low = 1'b0;
    if (wr_ready) wr_cnt++;
    if (rd_valid) begin rd_cnt++; rd_q.push_back(rd_data); end
    if (done) begin done_cnt++; done_t = cyc; end
    scl_prev  = scl_oe;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [NW-1:0] n);
    @(posedge clk); #1;
    addr = a; rw = r; nbytes = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({name, " done count"}, done_cnt, 1);
    check({name, " busy after done"}, busy, 0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string nm;
    logic [7:0] got;
    nm = $sformatf("vec%0d", k);
    s_ack_addr = v.ack_addr; s_ack_data = v.ack_data; s_rw = v.rw; s_n = v.n;
    s_rd[0] = v.rd0; s_rd[1] = v.rd1;
    wbytes[0] = v.wd0; wbytes[1] = v.wd1; wbytes[2] = 8'h00; wbytes[3] = 8'h00;
    exp_q.delete();
    if (v.exp_rd > 0) exp_q.push_back(v.rd0);
    if (v.exp_rd > 1) exp_q.push_back(v.rd1);
    launch(v.addr, v.rw, v.n);
    wait_done(nm);
    check({nm, " ack_err"}, ack_err, v.exp_err);
    check({nm, " clocks"}, done_t - busy_t, v.exp_cyc);
    check({nm, " wr_ready pulses"}, wr_cnt, v.exp_wr);
    check({nm, " rd_valid pulses"}, rd_cnt, v.exp_rd);
    check({nm, " addr bits"}, log_byte(0), {v.addr, v.rw});
    if (v.exp_wr > 0) check({nm, " data0 bits"}, log_byte(9), v.wd0);
    if (v.exp_wr > 1) check({nm, " data1 bits"}, log_byte(18), v.wd1);
    for (int j = 0; j < v.exp_rd; j++) begin
      got = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
      check($sformatf("%s rd byte %0d", nm, j), got, exp_q.pop_front());
      check($sformatf("%s master ack %0d", nm, j), mlog[17 + 9*j], (j == v.exp_rd - 1) ? 1 : 0);
    end
  endtask

  initial begin
    //            addr   rw  n   wd0    wd1    rd0    rd1   aa  ad  err cyc  wr rd
    vecs[0] = '{7'h50, 1'b0, 4'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 308, 1, 0};
    vecs[1] = '{7'h3C, 1'b0, 4'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 164, 0, 0};
    vecs[2] = '{7'h2A, 1'b1, 4'd2, 8'h00, 8'h00, 8'h12, 8'hF0, 1'b1, 1'b1, 1'b0, 452, 0, 2};
    vecs[3] = '{7'h48, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 164, 0, 0};
    vecs[4] = '{7'h11, 1'b0, 4'd2, 8'h5A, 8'h66, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 308, 1, 0};
    vecs[5] = '{7'h7F, 1'b0, 4'd2, 8'h3C, 8'hC3, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 452, 2, 0};
    for (int i = 0; i < 4; i++) wbytes[i] = 8'h00;
    s_rd[0] = 8'h00; s_rd[1] = 8'h00;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset scl_oe", scl_oe, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset wr_ready", wr_ready, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset state", state_dbg, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Busy guard: a second start mid-transfer must not disturb the first.
    s_ack_addr = 1'b1; s_ack_data = 1'b1; s_rw = 1'b0; s_n = 1;
    wbytes[0] = 8'hA5;
    launch(7'h50, 1'b0, 4'd1);
    repeat (100) @(posedge clk);
    launch(7'h3C, 1'b1, 4'd2);
    wait_done("guard");
    check("guard clocks", done_t - busy_t, 308);
    check("guard addr bits", log_byte(0), 8'hA0);
    check("guard data bits", log_byte(9), 8'hA5);
    check("guard wr_ready pulses", wr_cnt, 1);
    check("guard rd_valid pulses", rd_cnt, 0);
    check("guard ack_err", ack_err, 0);

    // Start on the done cycle is ignored.
    s_n = 0;
    launch(7'h48, 1'b0, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("donecyc done seen", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("donecyc busy next", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("donecyc busy later", busy, 0);

    // Reset in the middle of a write data byte.
    s_n = 1;
    launch(7'h50, 1'b0, 4'd1);
    repeat (200) @(posedge clk);
    #1;
    check("midrst busy before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst scl_oe", scl_oe, 0);
    check("midrst sda_oe", sda_oe, 0);
    check("midrst busy", busy, 0);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("midrst no done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
